// File: rtl/udt_pkg.sv
// Shared UDT control-packet definitions: control type codes, header/loss-word
// bit positions, header builder and the NAK generator state type.
package udt_pkg;

    localparam int CTRL_BIT  = 31;
    localparam int RANGE_BIT = 31;

    localparam logic [14:0] CTRL_HANDSHAKE = 15'h0000;
    localparam logic [14:0] CTRL_KEEPALIVE = 15'h0001;
    localparam logic [14:0] CTRL_ACK       = 15'h0002;
    localparam logic [14:0] CTRL_NAK       = 15'h0003;
    localparam logic [14:0] CTRL_SHUTDOWN  = 15'h0005;
    localparam logic [14:0] CTRL_ACK2      = 15'h0006;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        BODY  = 3'd3,
        FLUSH = 3'd4
    } nak_state_t;

    // Header word 0: control flag, 15-bit type, 16 reserved bits.
    function automatic logic [31:0] ctrl_hdr_word0(input logic [14:0] ctrl_type);
        logic [31:0] w;
        w           = '0;
        w[CTRL_BIT] = 1'b1;
        w[30:16]    = ctrl_type;
        return w;
    endfunction

    function automatic logic [31:0] loss_word(input logic range_flag, input logic [30:0] seq);
        logic [31:0] w;
        w            = {1'b0, seq};
        w[RANGE_BIT] = range_flag;
        return w;
    endfunction

endpackage

// File: rtl/udt_axis_reg.sv
// Single-slot 64-bit AXI-Stream output register shared by the UDT control
// packet generators; the producer loads a beat only while free is high.
module udt_axis_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic [7:0]  load_keep,
    input  logic        load_last,
    output logic        free,
    output logic [63:0] tdata,
    output logic [7:0]  tkeep,
    output logic        tvalid,
    output logic        tlast,
    input  logic        tready
);

    assign free = !tvalid || tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata  <= '0;
            tkeep  <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end else if (load && free) begin
            tdata  <= load_data;
            tkeep  <= load_keep;
            tvalid <= 1'b1;
            tlast  <= load_last;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/generate_nak.sv
// UDT NAK packet builder: packs loss entries behind a 16-byte control header.
// Optional statistics counters enabled by defining GENERATE_NAK_STATS_EN.
module generate_nak
    import udt_pkg::*;
#(
    parameter logic [14:0] CTRL_TYPE = CTRL_NAK,
    parameter logic [31:0] ADD_INFO  = 32'h0
`ifdef GENERATE_NAK_STATS_EN
    ,
    parameter int          STAT_W    = 32
`endif
) (
    input  logic              core_clk,
    input  logic              core_rst_n,
    input  logic [30:0]       loss_first,
    input  logic [30:0]       loss_last_seq,
    input  logic              loss_tvalid,
    output logic              loss_tready,
    input  logic              loss_tlast,
    input  logic [31:0]       timestamp,
    input  logic [31:0]       dst_sock_id,
    output logic [63:0]       NAK_tdata,
    output logic [7:0]        NAK_tkeep,
    output logic              NAK_tvalid,
    input  logic              NAK_tready,
`ifdef GENERATE_NAK_STATS_EN
    output logic [STAT_W-1:0] nak_pkt_cnt,
    output logic [STAT_W-1:0] nak_loss_cnt,
`endif
    output logic              NAK_tlast
);

    nak_state_t  state, state_n;
    logic [31:0] ts_q, sock_q;
    logic [31:0] pend, pend_n;
    logic        pend_vld, pend_vld_n;

    logic        free;
    logic        load;
    logic        load_last;
    logic [63:0] load_data;
    logic [7:0]  load_keep;

    logic        is_range;
    logic        accept;
    logic [31:0] w0, w1;

    assign is_range    = loss_first != loss_last_seq;
    assign w0          = loss_word(is_range, loss_first);
    assign w1          = loss_word(1'b0, loss_last_seq);
    assign loss_tready = (state == BODY) && free;
    assign accept      = loss_tvalid && loss_tready;

    always_comb begin
        state_n    = state;
        pend_n     = pend;
        pend_vld_n = pend_vld;
        load       = 1'b0;
        load_data  = '0;
        load_keep  = 8'hFF;
        load_last  = 1'b0;
        case (state)
            IDLE: begin
                if (loss_tvalid) state_n = HDR0;
            end
            HDR0: begin
                if (free) begin
                    load      = 1'b1;
                    load_data = {ctrl_hdr_word0(CTRL_TYPE), ADD_INFO};
                    state_n   = HDR1;
                end
            end
            HDR1: begin
                if (free) begin
                    load      = 1'b1;
                    load_data = {ts_q, sock_q};
                    state_n   = BODY;
                end
            end
            BODY: begin
                if (accept) begin
                    if (!pend_vld) begin
                        if (is_range) begin
                            load      = 1'b1;
                            load_data = {w0, w1};
                        end else begin
                            pend_n     = w0;
                            pend_vld_n = 1'b1;
                        end
                    end else begin
                        // Pending word always goes out first; a range leaves its second word behind.
                        load       = 1'b1;
                        load_data  = {pend, w0};
                        pend_n     = w1;
                        pend_vld_n = is_range;
                    end
                    if (loss_tlast) begin
                        if (pend_vld_n) begin
                            state_n = FLUSH;
                        end else begin
                            load_last = 1'b1;
                            state_n   = IDLE;
                        end
                    end
                end
            end
            FLUSH: begin
                if (free) begin
                    load       = 1'b1;
                    load_data  = {pend, 32'h0};
                    load_keep  = 8'hF0;
                    load_last  = 1'b1;
                    pend_vld_n = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state    <= IDLE;
            pend_vld <= 1'b0;
        end else begin
            state    <= state_n;
            pend_vld <= pend_vld_n;
        end
    end

    // Header fields and the pending word are plain data; validity is tracked by state/pend_vld.
    always_ff @(posedge core_clk) begin
        if (state == IDLE && loss_tvalid) begin
            ts_q   <= timestamp;
            sock_q <= dst_sock_id;
        end
        pend <= pend_n;
    end

    udt_axis_reg u_out (
        .clk       (core_clk),
        .rst_n     (core_rst_n),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .load_last (load_last),
        .free      (free),
        .tdata     (NAK_tdata),
        .tkeep     (NAK_tkeep),
        .tvalid    (NAK_tvalid),
        .tlast     (NAK_tlast),
        .tready    (NAK_tready)
    );

`ifdef GENERATE_NAK_STATS_EN
    logic [30:0] loss_span;

    // Span is taken modulo 2^31 so reversed ranges wrap instead of going negative.
    assign loss_span = loss_last_seq - loss_first + 31'd1;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            nak_pkt_cnt  <= '0;
            nak_loss_cnt <= '0;
        end else begin
            if (NAK_tvalid && NAK_tready && NAK_tlast) nak_pkt_cnt <= nak_pkt_cnt + STAT_W'(1);
            if (accept) nak_loss_cnt <= nak_loss_cnt + STAT_W'(loss_span);
        end
    end
`endif

endmodule

// File: tb/tb_generate_nak.sv
// Self-checking bench for generate_nak: directed packets plus randomized
// packets scored against a word-list reference model.
module tb_generate_nak;

    typedef logic [72:0] beat_t;  // {tdata, tkeep, tlast}
    typedef struct packed {
        logic [30:0] first;
        logic [30:0] last;
    } ent_t;

    logic        core_clk;
    logic        core_rst_n;
    logic [30:0] loss_first;
    logic [30:0] loss_last_seq;
    logic        loss_tvalid;
    logic        loss_tready;
    logic        loss_tlast;
    logic [31:0] timestamp;
    logic [31:0] dst_sock_id;
    logic [63:0] NAK_tdata;
    logic [7:0]  NAK_tkeep;
    logic        NAK_tvalid;
    logic        NAK_tready = 1'b1;
    logic        NAK_tlast;

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random, 3: never ready

    beat_t got_q[$];
    int    got_cyc[$];
    int    cyc       = 0;
    int    hold_err  = 0;
    int    ltr_err   = 0;
    bit    prev_stall = 0;
    beat_t prev_beat;

    ent_t  ent_q[$];
    beat_t exp_q[$];
    int    rd_idx = 0;

    generate_nak dut (
        .core_clk      (core_clk),
        .core_rst_n    (core_rst_n),
        .loss_first    (loss_first),
        .loss_last_seq (loss_last_seq),
        .loss_tvalid   (loss_tvalid),
        .loss_tready   (loss_tready),
        .loss_tlast    (loss_tlast),
        .timestamp     (timestamp),
        .dst_sock_id   (dst_sock_id),
        .NAK_tdata     (NAK_tdata),
        .NAK_tkeep     (NAK_tkeep),
        .NAK_tvalid    (NAK_tvalid),
        .NAK_tready    (NAK_tready),
        .NAK_tlast     (NAK_tlast)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) begin
        #2;
        case (rdy_mode)
            0:       NAK_tready = 1'b1;
            1:       NAK_tready = ~NAK_tready;
            2:       NAK_tready = 1'($urandom_range(0, 1));
            default: NAK_tready = 1'b0;
        endcase
    end

    // Output monitor: captures handshaked beats and watches stall behaviour.
    always @(negedge core_clk) begin
        cyc++;
        if (!core_rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && !(NAK_tvalid && ({NAK_tdata, NAK_tkeep, NAK_tlast} === prev_beat)))
                hold_err++;
            if (NAK_tvalid && !NAK_tready && loss_tready) ltr_err++;
            if (NAK_tvalid && NAK_tready) begin
                got_q.push_back({NAK_tdata, NAK_tkeep, NAK_tlast});
                got_cyc.push_back(cyc);
            end
            prev_stall = NAK_tvalid && !NAK_tready;
            prev_beat  = {NAK_tdata, NAK_tkeep, NAK_tlast};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: flatten entries to 32-bit words, then pair them into beats.
    task automatic model(input logic [31:0] ts, input logic [31:0] sock);
        logic [31:0] words[$];
        int          n;
        foreach (ent_q[i]) begin
            if (ent_q[i].first == ent_q[i].last) begin
                words.push_back({1'b0, ent_q[i].first});
            end else begin
                words.push_back({1'b1, ent_q[i].first});
                words.push_back({1'b0, ent_q[i].last});
            end
        end
        exp_q.push_back({32'h8003_0000, 32'h0, 8'hFF, 1'b0});
        exp_q.push_back({ts, sock, 8'hFF, 1'b0});
        n = words.size();
        for (int i = 0; i < n; i += 2) begin
            if (i + 1 < n) exp_q.push_back({words[i], words[i+1], 8'hFF, 1'(i + 2 >= n)});
            else           exp_q.push_back({words[i], 32'h0, 8'hF0, 1'b1});
        end
    endtask

    task automatic wait_accept();
        int n  = 0;
        bit ok = 0;
        while (n < 300 && !ok) begin
            @(negedge core_clk);
            if (loss_tready === 1'b1) ok = 1;
            n++;
        end
        if (ok) begin
            @(posedge core_clk);
            #1;
        end
        checks++;
        assert (ok === 1'b1) else begin
            failures++;
            $error("FAIL accept_timeout got=%0d want=1", ok);
        end
    endtask

    task automatic send_packet(input logic [31:0] ts, input logic [31:0] sock, input bit with_tlast);
        timestamp   = ts;
        dst_sock_id = sock;
        foreach (ent_q[i]) begin
            loss_first    = ent_q[i].first;
            loss_last_seq = ent_q[i].last;
            loss_tlast    = with_tlast && (i == ent_q.size() - 1);
            loss_tvalid   = 1'b1;
            wait_accept();
        end
        loss_tvalid = 1'b0;
        loss_tlast  = 1'b0;
    endtask

    task automatic check_pkt(input string tag);
        int    n = 0;
        beat_t got;
        while (got_q.size() < rd_idx + exp_q.size() && n < 400) begin
            @(negedge core_clk);
            n++;
        end
        repeat (3) @(negedge core_clk);
        checks++;
        assert (got_q.size() - rd_idx === exp_q.size()) else begin
            failures++;
            $error("FAIL %s beat_count got=%0d want=%0d", tag, got_q.size() - rd_idx, exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (rd_idx + i < got_q.size()) ? got_q[rd_idx + i] : 'x;
            checks++;
            assert (got === exp_q[i]) else begin
                failures++;
                $error("FAIL %s beat%0d got=%h want=%h", tag, i, got, exp_q[i]);
            end
        end
        rd_idx = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        int          base;
        int          gap;
        int          nb;
        logic [31:0] f, l, ts, sock;

        core_rst_n    = 1'b0;
        loss_first    = '0;
        loss_last_seq = '0;
        loss_tvalid   = 1'b0;
        loss_tlast    = 1'b0;
        timestamp     = '0;
        dst_sock_id   = '0;
        repeat (3) @(posedge core_clk);
        #1;
        checks += 5;
        assert (NAK_tvalid === 1'b0) else begin failures++; $error("FAIL rst_tvalid got=%b want=0", NAK_tvalid); end
        assert (NAK_tlast === 1'b0) else begin failures++; $error("FAIL rst_tlast got=%b want=0", NAK_tlast); end
        assert (NAK_tdata === 64'h0) else begin failures++; $error("FAIL rst_tdata got=%h want=0", NAK_tdata); end
        assert (NAK_tkeep === 8'h0) else begin failures++; $error("FAIL rst_tkeep got=%h want=0", NAK_tkeep); end
        assert (loss_tready === 1'b0) else begin failures++; $error("FAIL rst_loss_tready got=%b want=0", loss_tready); end
        core_rst_n = 1'b1;
        repeat (2) @(posedge core_clk);
        #1;

        // Single loss entry: flushed as a half beat.
        ent_q = '{'{31'h10, 31'h10}};
        send_packet(32'h1234, 32'hABCD, 1);
        exp_q.push_back({64'h80030000_00000000, 8'hFF, 1'b0});
        exp_q.push_back({64'h00001234_0000ABCD, 8'hFF, 1'b0});
        exp_q.push_back({64'h00000010_00000000, 8'hF0, 1'b1});
        check_pkt("single");

        // Single range: one full body beat.
        ent_q = '{'{31'h5, 31'h9}};
        send_packet(32'h1, 32'h2, 1);
        exp_q.push_back({64'h80030000_00000000, 8'hFF, 1'b0});
        exp_q.push_back({64'h00000001_00000002, 8'hFF, 1'b0});
        exp_q.push_back({64'h80000005_00000009, 8'hFF, 1'b1});
        check_pkt("range");

        // Mixed single/range/single straddling beats.
        ent_q = '{'{31'h1, 31'h1}, '{31'h3, 31'h4}, '{31'h7, 31'h7}};
        send_packet(32'h3, 32'h4, 1);
        exp_q.push_back({64'h80030000_00000000, 8'hFF, 1'b0});
        exp_q.push_back({64'h00000003_00000004, 8'hFF, 1'b0});
        exp_q.push_back({64'h00000001_80000003, 8'hFF, 1'b0});
        exp_q.push_back({64'h00000004_00000007, 8'hFF, 1'b1});
        check_pkt("mixed");

        // Range then single under toggling ready.
        rdy_mode = 1;
        ent_q = '{'{31'h40, 31'h42}, '{31'h50, 31'h50}};
        model(32'h55, 32'h66);
        send_packet(32'h55, 32'h66, 1);
        check_pkt("toggle");

        // Back-to-back packets with continuous ready.
        rdy_mode = 0;
        base = rd_idx;
        ent_q = '{'{31'h11, 31'h11}, '{31'h12, 31'h12}};
        model(32'hA, 32'hB);
        nb = exp_q.size();
        send_packet(32'hA, 32'hB, 1);
        ent_q = '{'{31'h20, 31'h28}};
        model(32'hC, 32'hD);
        send_packet(32'hC, 32'hD, 1);
        check_pkt("b2b");
        gap = (got_cyc.size() > base + nb) ? got_cyc[base + nb] - got_cyc[base + nb - 1] : 999;
        checks++;
        assert (gap >= 1 && gap <= 2) else begin
            failures++;
            $error("FAIL b2b_gap got=%0d want<=2", gap);
        end

        // Randomized packets across ready patterns.
        for (int p = 0; p < 24; p++) begin
            rdy_mode = p % 3;
            ent_q.delete();
            for (int e = 0; e < int'($urandom_range(1, 5)); e++) begin
                f = $urandom;
                l = ($urandom_range(0, 1) == 0) ? f : $urandom;
                ent_q.push_back('{f[30:0], l[30:0]});
            end
            ts   = $urandom;
            sock = $urandom;
            model(ts, sock);
            send_packet(ts, sock, 1);
            check_pkt("random");
        end

        // Reset while a word is pending and a body beat is stalled.
        rdy_mode = 0;
        ent_q = '{'{31'h21, 31'h21}, '{31'h30, 31'h31}};
        send_packet(32'h9, 32'h9, 0);
        rdy_mode = 3;
        @(negedge core_clk);
        checks++;
        assert (NAK_tvalid === 1'b1) else begin failures++; $error("FAIL pre_rst_tvalid got=%b want=1", NAK_tvalid); end
        #1 core_rst_n = 1'b0;
        #1;
        checks += 2;
        assert (NAK_tvalid === 1'b0) else begin failures++; $error("FAIL async_rst_tvalid got=%b want=0", NAK_tvalid); end
        assert (loss_tready === 1'b0) else begin failures++; $error("FAIL async_rst_loss_tready got=%b want=0", loss_tready); end
        repeat (2) @(posedge core_clk);
        #1;
        core_rst_n = 1'b1;
        rdy_mode   = 0;
        repeat (2) @(posedge core_clk);
        #1;
        rd_idx = got_q.size();
        ent_q = '{'{31'h60, 31'h60}};
        model(32'h77, 32'h88);
        send_packet(32'h77, 32'h88, 1);
        check_pkt("post_rst");

        checks += 2;
        assert (hold_err === 0) else begin failures++; $error("FAIL stall_hold got=%0d want=0", hold_err); end
        assert (ltr_err === 0) else begin failures++; $error("FAIL loss_tready_when_full got=%0d want=0", ltr_err); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/generate_nak.md
Name: generate_nak

Overview:
- Transmit-side counterpart of NAK processing: builds UDT NAK control packets from a stream of loss entries and emits them as 64-bit AXI-Stream.
- Sits between the receiver loss list and the control-packet TX mux.
- Each loss entry is either a single lost sequence number or a range; entries are packed two 32-bit words per beat behind a 16-byte UDT control header.

Parameters:
- CTRL_TYPE, 15'h0003, UDT control type field written into header word 0 (NAK).
- ADD_INFO, 32'h0, header word 1, the additional-info field.
- STAT_W, 32, width of the statistics counters (optional feature only).

Ports:
- core_clk  in  1  core clock.
- core_rst_n  in  1  reset; one clock, asynchronous, active-low.
- loss_first  in  31  first lost sequence number of the entry.
- loss_last_seq  in  31  last lost sequence number; equals loss_first for a single loss.
- loss_tvalid  in  1  entry valid.
- loss_tready  out  1  entry accepted when tvalid && tready.
- loss_tlast  in  1  final entry of this NAK packet.
- timestamp  in  32  sampled at packet start.
- dst_sock_id  in  32  sampled at packet start.
- NAK_tdata  out  64  packet data; the first word of each beat is in [63:32].
- NAK_tkeep  out  8  byte enables; bit 7 corresponds to tdata[63:56].
- NAK_tvalid  out  1  beat valid.
- NAK_tready  in  1  downstream ready.
- NAK_tlast  out  1  last beat of packet.

Behaviour:
- Reset values:
  - NAK_tvalid = 0, NAK_tlast = 0, NAK_tdata = 0, NAK_tkeep = 0, loss_tready = 0.
  - State = IDLE, pending-word valid cleared.
- Reset mid-packet aborts the packet silently. No tlast is emitted for the aborted packet.
- Output stage is a single register slot. The slot is "free" when !NAK_tvalid || NAK_tready. A state loads a beat only when the slot is free.
- NAK_tdata, NAK_tkeep and NAK_tlast hold stable while NAK_tvalid && !NAK_tready.
- Word encoding per entry:
  - Single (first == last): one word {1'b0, first}.
  - Range: two words {1'b1, first}, {1'b0, last}.
  - No ordering or wrap check is applied to ranges.
- FSM states: IDLE, HDR0, HDR1, BODY, FLUSH.
- IDLE:
  - loss_tready = 0.
  - On loss_tvalid, latch timestamp and dst_sock_id, then go to HDR0.
  - The entry is not consumed in IDLE.
- HDR0: on a free slot, load {1'b1, CTRL_TYPE, 16'h0, ADD_INFO} with tkeep FF and tlast 0. Go to HDR1.
  - Latency: if IDLE samples loss_tvalid at edge k, NAK_tvalid is high after edge k+1.
- HDR1: on a free slot, load {timestamp_q, sock_id_q} with tkeep FF. Go to BODY.
- BODY:
  - loss_tready = slot free.
  - Throughput is one entry per cycle. With pending-word valid p and entry word count w:
    - p=0, w=1: store word in pend, set p=1. No beat is loaded.
    - p=0, w=2: load {w0, w1}, tkeep FF.
    - p=1, w=1: load {pend, w0}, tkeep FF, clear p.
    - p=1, w=2: load {pend, w0}, tkeep FF, pend = w1, keep p=1.
  - If the accepted entry has loss_tlast:
    - If p is 1 after the update, go to FLUSH.
    - Otherwise the loaded beat carries tlast=1 and the state goes to IDLE.
- FLUSH: on a free slot, load {pend, 32'h0} with tkeep F0 and tlast 1. Clear p and go to IDLE.
- Back-to-back packets: IDLE may leave while the previous tlast beat is still stalled in the slot. HDR0 waits for the slot to be free.
- Packet length is bounded by upstream. The block enforces no MSS limit.

Optional Feature:
- Macro: GENERATE_NAK_STATS_EN.
- Defined: adds outputs nak_pkt_cnt[STAT_W-1:0] and nak_loss_cnt[STAT_W-1:0].
  - nak_pkt_cnt increments on each handshaked tlast beat.
  - nak_loss_cnt adds (last - first + 1) per accepted entry, computed modulo 2^31 and then zero-extended.
  - Both counters wrap and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- udt_pkg holds:
  - control type constants (NAK = 15'h0003, ACK, ACK2, ...);
  - control bit position 31;
  - the range-flag bit;
  - a header-word builder function;
  - the FSM state typedef.
- One sub-module, udt_axis_reg: the 64-bit AXIS single-slot output register with a load/free interface. It is reused by the other control-packet generators.

Test Plan:
- Single entry first=last=0x10, tlast; timestamp=0x1234, sock=0xABCD, tready=1:
  - beats are 0x80030000_00000000; 0x00001234_0000ABCD; 0x00000010_00000000 with tkeep F0 and tlast.
- Single range 0x5..0x9, tlast:
  - body is one beat 0x80000005_00000009, tkeep FF, tlast.
- Entries single 0x1, range 0x3..0x4, single 0x7(tlast):
  - body beats are 0x00000001_80000003, then 0x00000004_00000007 with tlast.
- NAK_tready toggled 1/0 each cycle on the range-then-single packet:
  - tdata, tkeep and tlast are held while stalled; no beat is lost or duplicated;
  - loss_tready stays 0 while the slot is full.
- Two packets back-to-back with tready=1:
  - the second HDR0 follows the first tlast beat with no idle gap beyond one cycle.
- core_rst_n asserted while in BODY with p=1:
  - NAK_tvalid drops immediately (asynchronous reset);
  - the next entry starts a clean packet with headers.
